// File: rtl/microwave_timer_ctrl.sv
// ============================================================================
// Module   : microwave_timer_ctrl
// Purpose  : MM:SS cook countdown with keypad entry, pause/resume and alarm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module microwave_timer_ctrl #(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       mag_on,
    output logic       done_pulse,
    output logic       beep,
    output logic       zero
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_COOK  = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;
    localparam logic [3:0] C_LAST_TICK = 4'(DONE_TICKS - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_pulse_q, done_pulse_d;
    logic       beep_q, beep_d;
    logic       zero_q, zero_d;
    logic       w_zero_now;
    logic       w_at_one;

    assign w_zero_now = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign w_at_one   = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            mt_q         <= 4'd0;
            mo_q         <= 4'd0;
            st_q         <= 4'd0;
            so_q         <= 4'd0;
            cnt_q        <= 4'd0;
            done_pulse_q <= 1'b0;
            beep_q       <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            mt_q         <= mt_d;
            mo_q         <= mo_d;
            st_q         <= st_d;
            so_q         <= so_d;
            cnt_q        <= cnt_d;
            done_pulse_q <= done_pulse_d;
            beep_q       <= beep_d;
            zero_q       <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    mt_d = 4'd0;
                    mo_d = 4'd0;
                    st_d = 4'd0;
                    so_d = 4'd0;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    if (door_closed && !w_zero_now)
                        state_d = S_COOK;
                end else if (key_valid && (key_digit <= 4'd9) && (so_q <= 4'd5)) begin
                    // Shift-in entry; a seconds-ones above 5 cannot become a tens digit.
                    mt_d = mo_q;
                    mo_d = st_q;
                    st_d = so_q;
                    so_d = key_digit;
                end
            end
            S_COOK: begin
                if (stop || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (tick_1hz && !clear && !start && !key_valid) begin
                    if (w_at_one) begin
                        state_d = S_DONE;
                        cnt_d   = 4'd0;
                    end
                    if (so_q != 4'd0) begin
                        so_d = so_q - 4'd1;
                    end else begin
                        so_d = 4'd9;
                        if (st_q != 4'd0) begin
                            st_d = st_q - 4'd1;
                        end else begin
                            st_d = 4'd5;
                            if (mo_q != 4'd0) begin
                                mo_d = mo_q - 4'd1;
                            end else begin
                                mo_d = 4'd9;
                                mt_d = mt_q - 4'd1;
                            end
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                end else if (start && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (stop || start) begin
                    state_d = S_IDLE;
                end else if (tick_1hz && !clear && !key_valid) begin
                    if (cnt_q >= C_LAST_TICK)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Door interlock must cut the magnetron without waiting for a clock edge.
    always_comb begin
        mag_on       = (state_q == S_COOK) && door_closed;
        done_pulse_d = (state_d == S_DONE) && (state_q != S_DONE);
        beep_d       = (state_d == S_DONE);
        zero_d       = (mt_d == 4'd0) && (mo_d == 4'd0) && (st_d == 4'd0) && (so_d == 4'd0);
    end

    assign min_tens   = mt_q;
    assign min_ones   = mo_q;
    assign sec_tens   = st_q;
    assign sec_ones   = so_q;
    assign state      = state_q;
    assign done_pulse = done_pulse_q;
    assign beep       = beep_q;
    assign zero       = zero_q;

endmodule

`default_nettype wire
